fifo_ctrl: RTL



---
 rtl/fifo_ctrl.sv | 100 ++++++++++
 1 files changed

// File: rtl/fifo_ctrl.sv
// Pointer and status controller for a circular FIFO around a dual-address register file.
// Turns push/pop requests into write strobe and addresses, tracks occupancy and flags.
module fifo_ctrl #(
    parameter int ADDR_WIDTH = 2,
    parameter int AF_LEVEL   = 3,
    parameter int AE_LEVEL   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  rd,
    input  logic                  clr_err,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int CW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
    localparam logic [CW-1:0]         CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]         CNT_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0]         CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0]         CNT_AF    = CW'(AF_LEVEL);
    localparam logic [CW-1:0]         CNT_AE    = CW'(AE_LEVEL);

    logic          do_wr_s;
    logic          do_rd_s;
    logic          ovf_set_s;
    logic          unf_set_s;
    logic [CW-1:0] count_next_s;

    // Accept/drop decisions and next occupancy; a full FIFO may push only while popping.
    always_comb begin
        do_wr_s      = 1'b0;
        do_rd_s      = 1'b0;
        ovf_set_s    = 1'b0;
        unf_set_s    = 1'b0;
        count_next_s = count;
        if (reset) begin
            do_wr_s = 1'b0;
            do_rd_s = 1'b0;
        end else begin
            do_wr_s   = wr & (~full | rd);
            do_rd_s   = rd & ~empty;
            ovf_set_s = wr & full & ~rd;
            unf_set_s = rd & empty & ~wr;
        end
        case ({do_wr_s, do_rd_s})
            2'b10:   count_next_s = count + CNT_ONE;
            2'b01:   count_next_s = count - CNT_ONE;
            default: count_next_s = count;
        endcase
    end

    assign wr_en = do_wr_s;

    // Pointers, occupancy and flags, all derived from next-state count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_addr       <= '0;
            r_addr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (do_wr_s) begin
                w_addr <= w_addr + PTR_ONE;
            end else begin
                w_addr <= w_addr;
            end
            if (do_rd_s) begin
                r_addr <= r_addr + PTR_ONE;
            end else begin
                r_addr <= r_addr;
            end
            count        <= count_next_s;
            full         <= (count_next_s == CNT_DEPTH);
            empty        <= (count_next_s == CNT_ZERO);
            almost_full  <= (count_next_s >= CNT_AF);
            almost_empty <= (count_next_s <= CNT_AE);
            // Set wins over a simultaneous clear.
            overflow     <= ovf_set_s | (overflow & ~clr_err);
            underflow    <= unf_set_s | (underflow & ~clr_err);
        end
    end

endmodule
